// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg: shared timing constants, pipeline control type and the
// frame-buffer address helper for the VGA scan-out block.
//   No ports; imported by vga_scanout_if, vga_vram and vga_scanout.
package vga_scanout_pkg;

    // 640x480@60 horizontal timing, in pixel clocks
    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_TOT  = 10'd800;

    // Vertical timing, in lines
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_TOT  = 10'd525;

    localparam logic [9:0] H_SYNC_BEG = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam logic [9:0] V_SYNC_BEG = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END = V_SYNC_BEG + V_SYNC;

    // Each stored pixel covers a 4x4 block of screen pixels
    localparam int unsigned FB_SHIFT = 2;
    localparam int unsigned FB_DEPTH = 19200;
    localparam int unsigned FB_AW    = 15;

    typedef logic [11:0] rgb_t;

    // Per-pixel control travelling alongside the RAM read
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic vblank;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, vblank: 1'b0};

    // row*160 + col, built from shifts so no multiplier is inferred
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] row, input logic [7:0] col);
        logic [FB_AW-1:0] r;
        r = {7'd0, row};
        return (r << 7) + (r << 5) + {7'd0, col};
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: pixel write port from the MEM stage plus the VGA outputs.
//   we/haddr/vaddr/wrgb : pixel write strobe, column, row, colour {R,G,B}
//   R/G/B               : 4-bit colour channels
//   hs/vs               : active-low syncs
//   vblank              : high during vertical blanking
interface vga_scanout_if;
    import vga_scanout_pkg::*;

    logic       we;
    logic [7:0] haddr;
    logic [7:0] vaddr;
    rgb_t       wrgb;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;
    logic       hs;
    logic       vs;
    logic       vblank;

    modport master (
        output we, haddr, vaddr, wrgb,
        input  R, G, B, hs, vs, vblank
    );

    modport slave (
        input  we, haddr, vaddr, wrgb,
        output R, G, B, hs, vs, vblank
    );

endinterface

// File: rtl/vga_vram.sv
// vga_vram: simple dual-port frame-buffer RAM, read-first, registered read.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, valid one clk after raddr
module vga_vram
    import vga_scanout_pkg::*;
#(
    parameter int unsigned Depth = FB_DEPTH,
    parameter int unsigned Width = 12,
    parameter int unsigned AddrW = FB_AW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    // Non-blocking read and write in one block: a same-address collision
    // returns the contents from before this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: stores 160x120 12-bit pixels and scans them out as 640x480@60
// VGA with 4x4 pixel replication.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   bus    : vga_scanout_if.slave (pixel write port in, R/G/B/hs/vs/vblank out)
// Outputs lag the pixel counters by exactly 3 clk.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned FB_W    = 160,
    parameter int unsigned FB_H    = 120
) (
    input  logic         clk,
    input  logic         rst,
    vga_scanout_if.slave bus
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
    localparam logic [7:0] FbW = 8'(FB_W);
    localparam logic [7:0] FbH = 8'(FB_H);

    logic [DivW-1:0] pdiv_q;
    logic [9:0]      hcnt_q;
    logic [9:0]      vcnt_q;
    logic            pe;

    logic             wr_en;
    logic [FB_AW-1:0] wr_addr;
    logic [FB_AW-1:0] rd_addr_d;
    logic [FB_AW-1:0] rd_addr_q;
    rgb_t             rd_data;

    ctrl_t ctrl1_d;
    ctrl_t ctrl1_q;
    ctrl_t ctrl2_q;
    rgb_t  rgb_q;
    logic  hs_q;
    logic  vs_q;
    logic  vblank_q;

    assign pe = (pdiv_q == DivMax);

    // Divider and raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pdiv_q <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (pe) begin
            pdiv_q <= '0;
            if (hcnt_q == H_TOT - 10'd1) begin
                hcnt_q <= '0;
                vcnt_q <= (vcnt_q == V_TOT - 10'd1) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_q <= hcnt_q + 10'd1;
            end
        end else begin
            pdiv_q <= pdiv_q + DivW'(1);
        end
    end

    // Write side: out-of-range coordinates are dropped
    assign wr_en   = bus.we && (bus.haddr < FbW) && (bus.vaddr < FbH);
    assign wr_addr = fb_addr(bus.vaddr, bus.haddr);

    always_comb begin
        ctrl1_d        = CTRL_IDLE;
        ctrl1_d.active = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        ctrl1_d.hs     = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
        ctrl1_d.vs     = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
        ctrl1_d.vblank = (vcnt_q >= V_VIS);
        // Blanking area would address past the buffer; park on 0 instead
        rd_addr_d = ctrl1_d.active ?
                    fb_addr(vcnt_q[9:FB_SHIFT], hcnt_q[9:FB_SHIFT]) : '0;
    end

    vga_vram #(
        .Depth (FB_DEPTH),
        .Width (12),
        .AddrW (FB_AW)
    ) u_vram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.wrgb),
        .raddr (rd_addr_q),
        .rdata (rd_data)
    );

    // T1: address/control, T2: RAM data + delayed control, T3: outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            ctrl1_q   <= CTRL_IDLE;
            ctrl2_q   <= CTRL_IDLE;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            vblank_q  <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            ctrl1_q   <= ctrl1_d;
            ctrl2_q   <= ctrl1_q;
            rgb_q     <= ctrl2_q.active ? rd_data : '0;
            hs_q      <= ctrl2_q.hs;
            vs_q      <= ctrl2_q.vs;
            vblank_q  <= ctrl2_q.vblank;
        end
    end

    assign bus.R      = rgb_q[11:8];
    assign bus.G      = rgb_q[7:4];
    assign bus.B      = rgb_q[3:0];
    assign bus.hs     = hs_q;
    assign bus.vs     = vs_q;
    assign bus.vblank = vblank_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout. A raster model derived from the VGA timing rules
// predicts every output on every cycle; directed literal checks pin the model.
module tb_vga_scanout;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_scanout_if bus ();

    vga_scanout #(
        .CLK_DIV (CLK_DIV),
        .FB_W    (160),
        .FB_H    (120)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          g;
        int          row;
        int          col;
        logic [11:0] d;
    } wr_t;

    wr_t         pend[$];
    logic [11:0] fb [120][160];
    int          g = 0;        // absolute edge count
    int          k = 0;        // edges since last reset release (0 while in reset)
    bit          started = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          falls[$];
    int          rises[$];
    logic        hs_prev = 1'b1;

    localparam logic [14:0] RESET_OUT = {12'h000, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    endtask

    // Expected {rgb, hs, vs, vblank} kk edges after reset release
    function automatic logic [14:0] model_out(input int kk);
        int          c, p, h, v;
        logic [11:0] rgb;
        if (kk < 3) return RESET_OUT;
        c = kk - 3;
        p = c / CLK_DIV;
        h = p % 800;
        v = (p / 800) % 525;
        rgb = (h < 640 && v < 480) ? fb[v / 4][h / 4] : 12'h000;
        return {rgb, !(h >= 656 && h < 752), !(v >= 490 && v < 492), v >= 480};
    endfunction

    function automatic logic [14:0] dut_out();
        return {bus.R, bus.G, bus.B, bus.hs, bus.vs, bus.vblank};
    endfunction

    initial begin
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++) fb[r][c] = 12'h000;
    end

    always @(posedge clk) begin
        g <= g + 1;
        k <= rst ? 0 : k + 1;
        started <= 1'b1;
        if (bus.we && bus.haddr < 160 && bus.vaddr < 120)
            pend.push_back('{g: g + 1, row: int'(bus.vaddr), col: int'(bus.haddr), d: bus.wrgb});
    end

    // A write is seen by reads from two edges later (the RAM read edge
    // for this output precedes it by one, and is read-first)
    always @(negedge clk) begin
        if (started) begin
            while (pend.size() > 0 && pend[0].g + 2 <= g) begin
                fb[pend[0].row][pend[0].col] = pend[0].d;
                void'(pend.pop_front());
            end
            check("scan", {17'd0, dut_out()}, {17'd0, model_out(k)});
        end
    end

    always @(negedge clk) begin
        if (hs_prev === 1'b1 && bus.hs === 1'b0) falls.push_back(k);
        if (hs_prev === 1'b0 && bus.hs === 1'b1) rises.push_back(k);
        hs_prev <= bus.hs;
    end

    task automatic wait_k(input int t);
        int guard = 0;
        while (k != t && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (k != t) begin
            n_checks++;
            $display("FAIL wait_k: k=%0d target %0d", k, t);
        end
    endtask

    task automatic wr(input int col, input int row, input logic [11:0] d);
        bus.haddr = 8'(col);
        bus.vaddr = 8'(row);
        bus.wrgb  = d;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.we = 1'b0;
        bus.haddr = '0;
        bus.vaddr = '0;
        bus.wrgb = '0;
        repeat (3) @(negedge clk);
        check("reset_values", {17'd0, dut_out()}, {17'd0, RESET_OUT});

        // Clear the rows this run scans, then place test pixels
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 160; c++) wr(c, r, 12'h000);
        wr(0, 0, 12'hF00);
        wr(159, 0, 12'h00F);
        wr(159, 119, 12'h00F);
        wr(0, 1, 12'h0F0);
        wr(160, 0, 12'hFFF);   // would alias onto (0,1) if not dropped
        wr(0, 120, 12'hFFF);
        rst = 1'b0;

        wait_k(3);
        check("red_origin", {20'd0, bus.R, bus.G, bus.B}, 32'hF00);
        wait_k(18);
        check("red_h3", {20'd0, bus.R, bus.G, bus.B}, 32'hF00);
        wait_k(19);
        check("black_h4", {20'd0, bus.R, bus.G, bus.B}, 32'h000);
        wait_k(2547);
        check("blue_h636", {20'd0, bus.R, bus.G, bus.B}, 32'h00F);
        wait_k(2563);
        check("black_h640", {20'd0, bus.R, bus.G, bus.B}, 32'h000);
        wait_k(3020);
        check("hs_first_fall", falls.size() > 0 ? falls[0] : -1, 2627);
        check("hs_low_width",
              (falls.size() > 0 && rises.size() > 0) ? rises[0] - falls[0] : -1, 384);
        wait_k(6000);
        check("hs_period", falls.size() > 1 ? falls[1] - falls[0] : -1, 3200);
        wait_k(12803);
        check("row1_preload_no_alias", {20'd0, bus.R, bus.G, bus.B}, 32'h0F0);

        // Collide with the last read of (0,1) on line 5
        wait_k(16016);
        bus.haddr = 8'd0;
        bus.vaddr = 8'd1;
        bus.wrgb  = 12'hF0F;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we    = 1'b0;
        wait_k(16018);
        check("collision_old", {20'd0, bus.R, bus.G, bus.B}, 32'h0F0);
        wait_k(19203);
        check("collision_new", {20'd0, bus.R, bus.G, bus.B}, 32'hF0F);

        // Reset mid-frame while inside hsync (hcnt 700, vcnt 8)
        wait_k(28400);
        check("pre_reset_hs", {31'd0, bus.hs}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {17'd0, dut_out()}, {17'd0, RESET_OUT});
        repeat (2) @(negedge clk);
        falls.delete();
        rises.delete();
        rst = 1'b0;
        wait_k(3);
        check("restart_origin", {20'd0, bus.R, bus.G, bus.B}, 32'hF00);
        wait_k(3020);
        check("hs_fall_after_reset", falls.size() > 0 ? falls[0] : -1, 2627);
        wait_k(9700);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
